// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/execute with variable-latency multiply,
// sticky illegal-opcode detection, halt/resume and a retired-instruction counter.
module ctrl_sequencer #(
    parameter int OPCODE_W    = 3,
    parameter int ULA_OP_W    = 2,
    parameter int MULT_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                instr_valid,
    input  logic                resume,
    output logic [ULA_OP_W-1:0] ula_op,
    output logic                pc_en,
    output logic                mem_wr,
    output logic                acc_en,
    output logic                ir_load,
    output logic                busy,
    output logic                halted,
    output logic                illegal,
    output logic [CNT_W-1:0]    retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MWAIT,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_STOP = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_SET  = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_MULT = 3'd5;

    localparam logic [ULA_OP_W-1:0] ULA_NONE = ULA_OP_W'(0);
    localparam logic [ULA_OP_W-1:0] ULA_LOAD = ULA_OP_W'(1);
    localparam logic [ULA_OP_W-1:0] ULA_ADD  = ULA_OP_W'(2);
    localparam logic [ULA_OP_W-1:0] ULA_MULT = ULA_OP_W'(3);

    // EXEC counts as the first multiply cycle, and MWAIT exits on zero, hence -2
    localparam logic [7:0] MULT_PRELOAD = (MULT_CYCLES >= 2) ? 8'(MULT_CYCLES - 2) : 8'd0;

    state_t                state_reg, state_next;
    logic [OPCODE_W-1:0]   ir_reg;
    logic [7:0]            cnt_reg;
    logic                  illegal_reg;
    logic [CNT_W-1:0]      retired_reg;

    logic                  cnt_load;
    logic                  cnt_dec;
    logic                  set_illegal;
    logic                  clr_illegal;
    logic                  ir_high_zero;

    assign ir_high_zero = ((ir_reg >> 3) == '0);

    always_comb begin
        state_next  = state_reg;
        ula_op      = ULA_NONE;
        pc_en       = 1'b0;
        mem_wr      = 1'b0;
        acc_en      = 1'b0;
        ir_load     = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        set_illegal = 1'b0;
        clr_illegal = 1'b0;

        unique case (state_reg)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_load    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                busy       = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                busy       = 1'b1;
                state_next = S_FETCH;
                if (!ir_high_zero) begin
                    set_illegal = 1'b1;
                    state_next  = S_HALT;
                end else begin
                    unique case (ir_reg[2:0])
                        OP_NOP:  pc_en = 1'b1;
                        OP_STOP: state_next = S_HALT;
                        OP_LOAD: begin
                            ula_op = ULA_LOAD;
                            acc_en = 1'b1;
                            pc_en  = 1'b1;
                        end
                        OP_SET: begin
                            mem_wr = 1'b1;
                            pc_en  = 1'b1;
                        end
                        OP_ADD: begin
                            ula_op = ULA_ADD;
                            acc_en = 1'b1;
                            pc_en  = 1'b1;
                        end
                        OP_MULT: begin
                            ula_op = ULA_MULT;
                            if (MULT_CYCLES == 1) begin
                                acc_en = 1'b1;
                                pc_en  = 1'b1;
                            end else begin
                                cnt_load   = 1'b1;
                                state_next = S_MWAIT;
                            end
                        end
                        default: begin
                            set_illegal = 1'b1;
                            state_next  = S_HALT;
                        end
                    endcase
                end
            end
            S_MWAIT: begin
                busy   = 1'b1;
                ula_op = ULA_MULT;
                if (cnt_reg == 8'd0) begin
                    acc_en     = 1'b1;
                    pc_en      = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (resume) begin
                    clr_illegal = 1'b1;
                    state_next  = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            ir_reg      <= '0;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            retired_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (ir_load) begin
                ir_reg <= opcode;
            end
            if (cnt_load) begin
                cnt_reg <= MULT_PRELOAD;
            end else if (cnt_dec) begin
                cnt_reg <= cnt_reg - 8'd1;
            end
            if (set_illegal) begin
                illegal_reg <= 1'b1;
            end else if (clr_illegal) begin
                illegal_reg <= 1'b0;
            end
            if (pc_en) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    assign illegal = illegal_reg;
    assign retired = retired_reg;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: three parameter variants driven in lockstep, checked each cycle
// against a timeline model, plus directed literal expectations.
module tb_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] opcode = 3'd0;
    logic       instr_valid = 1'b0;
    logic       resume = 1'b0;

    logic [1:0] ula [3];
    logic       pc  [3];
    logic       mw  [3];
    logic       acc [3];
    logic       irl [3];
    logic       bsy [3];
    logic       hlt [3];
    logic       ill [3];
    logic [15:0] ret_a, ret_c;
    logic [3:0]  ret_b;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.MULT_CYCLES(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid), .resume(resume),
        .ula_op(ula[0]), .pc_en(pc[0]), .mem_wr(mw[0]), .acc_en(acc[0]), .ir_load(irl[0]),
        .busy(bsy[0]), .halted(hlt[0]), .illegal(ill[0]), .retired(ret_a));
    ctrl_sequencer #(.MULT_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid), .resume(resume),
        .ula_op(ula[1]), .pc_en(pc[1]), .mem_wr(mw[1]), .acc_en(acc[1]), .ir_load(irl[1]),
        .busy(bsy[1]), .halted(hlt[1]), .illegal(ill[1]), .retired(ret_b));
    ctrl_sequencer #(.MULT_CYCLES(8), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid), .resume(resume),
        .ula_op(ula[2]), .pc_en(pc[2]), .mem_wr(mw[2]), .acc_en(acc[2]), .ir_load(irl[2]),
        .busy(bsy[2]), .halted(hlt[2]), .illegal(ill[2]), .retired(ret_c));

    // Timeline model: mode 0 = waiting for fetch, 1 = instruction in flight, 2 = halted.
    // t counts cycles since the accepting cycle; the last execute cycle is t = 1 + latency.
    int m_mc [3] = '{4, 1, 8};
    int m_cw [3] = '{16, 4, 16};
    int ms_mode [3] = '{0, 0, 0};
    int ms_t    [3] = '{0, 0, 0};
    int ms_op   [3] = '{0, 0, 0};
    int ms_ill  [3] = '{0, 0, 0};
    int ms_ret  [3] = '{0, 0, 0};

    function automatic int dut_ret(int i);
        if (i == 0) return int'(ret_a);
        if (i == 1) return int'(ret_b);
        return int'(ret_c);
    endfunction

    task automatic expect_out(input int i, output int e_ula, output int e_pc, output int e_mw,
                              output int e_acc, output int e_irl, output int e_busy,
                              output int e_hlt, output int e_ill, output int e_ret);
        int last;
        bit fin;
        e_ula = 0; e_pc = 0; e_mw = 0; e_acc = 0; e_irl = 0; e_busy = 0; e_hlt = 0;
        e_ill = ms_ill[i];
        e_ret = ms_ret[i];
        if (rst) begin
            e_irl = int'(instr_valid);
            e_ill = 0;
            e_ret = 0;
        end else if (ms_mode[i] == 2) begin
            e_hlt = 1;
        end else if (ms_mode[i] == 0) begin
            e_irl = int'(instr_valid);
        end else begin
            e_busy = 1;
            last = 1 + ((ms_op[i] == 5) ? m_mc[i] : 1);
            fin = (ms_t[i] == last);
            if (ms_op[i] == 2 && ms_t[i] == 2) e_ula = 1;
            if (ms_op[i] == 4 && ms_t[i] == 2) e_ula = 2;
            if (ms_op[i] == 5 && ms_t[i] >= 2) e_ula = 3;
            if (fin && (ms_op[i] == 2 || ms_op[i] == 4 || ms_op[i] == 5)) e_acc = 1;
            if (fin && ms_op[i] != 1 && ms_op[i] <= 5) e_pc = 1;
            if (fin && ms_op[i] == 3) e_mw = 1;
        end
    endtask

    always @(posedge clk) begin
        int e_ula, e_pc, e_mw, e_acc, e_irl, e_busy, e_hlt, e_ill, e_ret, last;
        for (int i = 0; i < 3; i++) begin
            expect_out(i, e_ula, e_pc, e_mw, e_acc, e_irl, e_busy, e_hlt, e_ill, e_ret);
            if (rst) begin
                ms_mode[i] = 0; ms_t[i] = 0; ms_op[i] = 0; ms_ill[i] = 0; ms_ret[i] = 0;
            end else if (ms_mode[i] == 0) begin
                if (instr_valid) begin
                    ms_mode[i] = 1; ms_t[i] = 1; ms_op[i] = int'(opcode);
                end
            end else if (ms_mode[i] == 2) begin
                if (resume) begin
                    ms_mode[i] = 0; ms_ill[i] = 0;
                end
            end else begin
                if (e_pc == 1) ms_ret[i] = (ms_ret[i] + 1) % (1 << m_cw[i]);
                last = 1 + ((ms_op[i] == 5) ? m_mc[i] : 1);
                if (ms_t[i] == last) begin
                    if (ms_op[i] == 1 || ms_op[i] > 5) begin
                        ms_mode[i] = 2;
                        if (ms_op[i] > 5) ms_ill[i] = 1;
                    end else begin
                        ms_mode[i] = 0;
                    end
                end else begin
                    ms_t[i] = ms_t[i] + 1;
                end
            end
        end
        started = 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int e_ula, e_pc, e_mw, e_acc, e_irl, e_busy, e_hlt, e_ill, e_ret;
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                expect_out(i, e_ula, e_pc, e_mw, e_acc, e_irl, e_busy, e_hlt, e_ill, e_ret);
                chk($sformatf("model_ula[%0d]", i), int'(ula[i]), e_ula);
                chk($sformatf("model_pc[%0d]", i), int'(pc[i]), e_pc);
                chk($sformatf("model_mw[%0d]", i), int'(mw[i]), e_mw);
                chk($sformatf("model_acc[%0d]", i), int'(acc[i]), e_acc);
                chk($sformatf("model_irl[%0d]", i), int'(irl[i]), e_irl);
                chk($sformatf("model_busy[%0d]", i), int'(bsy[i]), e_busy);
                chk($sformatf("model_halted[%0d]", i), int'(hlt[i]), e_hlt);
                chk($sformatf("model_illegal[%0d]", i), int'(ill[i]), e_ill);
                chk($sformatf("model_retired[%0d]", i), dut_ret(i), e_ret);
            end
            if (irl[0] && !rst)
                $display("txn dut_a accept opcode=%0d retired=%0d t=%0t", opcode, ret_a, $time);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        resume = 1'b0;
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        // Reset state with instr_valid high: ir_load follows it, everything else zero
        instr_valid = 1'b1;
        @(negedge clk);
        chk("rst_irl", int'(irl[0]), 1);
        chk("rst_halted", int'(hlt[0]), 0);
        chk("rst_retired", int'(ret_a), 0);
        next_cycle();
        pulse_reset();

        // NOP
        for (int c = 0; c <= 3; c++) begin
            instr_valid = (c == 0); opcode = 3'd0;
            @(negedge clk);
            if (c == 0) chk("nop_irl", int'(irl[0]), 1);
            chk("nop_pc", int'(pc[0]), int'(c == 2));
            chk("nop_ula", int'(ula[0]), 0);
            if (c == 3) chk("nop_retired", int'(ret_a), 1);
            next_cycle();
        end

        // LOAD, ADD, SET back-to-back
        for (int c = 0; c <= 9; c++) begin
            instr_valid = (c <= 8);
            opcode = (c < 3) ? 3'd2 : (c < 6) ? 3'd4 : 3'd3;
            @(negedge clk);
            chk("stream_irl", int'(irl[0]), int'(c == 0 || c == 3 || c == 6));
            chk("stream_mw", int'(mw[0]), int'(c == 8));
            if (c == 2) begin chk("load_ula", int'(ula[0]), 1); chk("load_acc", int'(acc[0]), 1); end
            if (c == 5) begin chk("add_ula", int'(ula[0]), 2); chk("add_acc", int'(acc[0]), 1); end
            if (c == 8) begin chk("set_ula", int'(ula[0]), 0); chk("set_acc", int'(acc[0]), 0); end
            if (c == 9) chk("stream_retired", int'(ret_a), 4);
            next_cycle();
        end

        // MULT: dut_a latency 4, dut_b latency 1, dut_c latency 8
        for (int c = 0; c <= 14; c++) begin
            instr_valid = (c <= 6); opcode = 3'd5;
            @(negedge clk);
            if (c <= 6) begin
                chk("mult4_ula", int'(ula[0]), (c >= 2 && c <= 5) ? 3 : 0);
                chk("mult4_acc", int'(acc[0]), int'(c == 5));
                chk("mult4_pc", int'(pc[0]), int'(c == 5));
            end
            if (c == 6) chk("mult4_next_irl", int'(irl[0]), 1);
            if (c <= 2) chk("mult1_pc", int'(pc[1]), int'(c == 2));
            if (c == 2) chk("mult1_ula", int'(ula[1]), 3);
            if (c == 3) chk("mult1_next_irl", int'(irl[1]), 1);
            next_cycle();
        end

        // Illegal opcode 7, then resume
        for (int c = 0; c <= 11; c++) begin
            instr_valid = (c == 0); opcode = 3'd7; resume = (c == 10);
            @(negedge clk);
            if (c <= 10) begin
                chk("ill_halted", int'(hlt[0]), int'(c >= 3));
                chk("ill_flag", int'(ill[0]), int'(c >= 3));
                chk("ill_pc", int'(pc[0]), 0);
            end else begin
                chk("ill_resume_halted", int'(hlt[0]), 0);
                chk("ill_resume_flag", int'(ill[0]), 0);
                chk("ill_resume_busy", int'(bsy[0]), 0);
            end
            next_cycle();
        end
        resume = 1'b0;

        // STOP halts without illegal
        for (int c = 0; c <= 5; c++) begin
            instr_valid = (c == 0); opcode = 3'd1; resume = (c == 4);
            @(negedge clk);
            if (c == 3) begin
                chk("stop_halted", int'(hlt[0]), 1);
                chk("stop_illegal", int'(ill[0]), 0);
            end
            if (c == 5) chk("stop_resumed", int'(hlt[0]), 0);
            next_cycle();
        end
        resume = 1'b0;

        // Reset in the middle of an 8-cycle multiply
        pulse_reset();
        for (int c = 0; c <= 20; c++) begin
            instr_valid = (c == 0); opcode = 3'd5; rst = (c == 3 || c == 4);
            @(negedge clk);
            if (c == 3) begin
                chk("abort_ula", int'(ula[2]), 0);
                chk("abort_acc", int'(acc[2]), 0);
                chk("abort_busy", int'(bsy[2]), 0);
                chk("abort_halted", int'(hlt[2]), 0);
            end
            if (c >= 3) chk("abort_pc", int'(pc[2]), 0);
            if (c == 20) chk("abort_retired", int'(ret_c), 0);
            next_cycle();
        end
        rst = 1'b0;

        // Retired counter wrap on the 4-bit variant
        pulse_reset();
        for (int c = 0; c <= 48; c++) begin
            instr_valid = (c < 48); opcode = 3'd0;
            @(negedge clk);
            if (c == 45) chk("wrap_before", int'(ret_b), 15);
            if (c == 48) begin
                chk("wrap_after", int'(ret_b), 0);
                chk("wrap_wide", int'(ret_a), 16);
            end
            next_cycle();
        end
        instr_valid = 1'b0;
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
